// File: rtl/ifetch.sv
// RV32I instruction fetch: owns the PC, drives a one-outstanding req/gnt/rvalid
// fetch port and the IF/ID register. Optional: IFETCH_MISALIGN_CHECK_EN.
module ifetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_id_valid,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic                  if_id_misalign
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_ERR} state_t;

  state_t                r_state, w_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, r_req_pc;
  logic                  r_buf_valid;
  logic [DATA_WIDTH-1:0] r_buf_instr;
  logic [ADDR_WIDTH-1:0] r_buf_pc;
  logic                  r_if_id_valid;
  logic [DATA_WIDTH-1:0] r_if_id_instr;
  logic [ADDR_WIDTH-1:0] r_if_id_pc;
  logic                  r_if_id_misalign;
  logic                  r_mis_pend;  // misaligned-target entry still owed to IF/ID
  logic                  r_mis_tgt;   // current target is misaligned: park in ERR

  logic                  w_gnt, w_rsp, w_mis;
  logic [ADDR_WIDTH-1:0] w_tgt;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign w_mis = redirect & (|redirect_pc[1:0]);
  assign w_tgt = redirect_pc;
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^redirect_pc[1:0];
  assign w_mis        = 1'b0;
  assign w_tgt        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
`endif

  assign imem_addr = r_pc;
  assign imem_req  = ~rst & (((r_state == S_REQ) & ~r_buf_valid) |
                             ((r_state == S_WAIT) & imem_rvalid & ~stall));
  assign w_gnt     = imem_req & imem_gnt;
  assign w_rsp     = (r_state == S_WAIT) & imem_rvalid;

  assign if_id_valid    = r_if_id_valid;
  assign if_id_instr    = r_if_id_instr;
  assign if_id_pc       = r_if_id_pc;
  assign if_id_misalign = r_if_id_misalign;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_REQ:   if (w_gnt) w_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid && !w_gnt) w_nxt = S_REQ;
      S_DROP:  if (imem_rvalid) w_nxt = r_mis_tgt ? S_ERR : S_REQ;
      default: w_nxt = S_ERR;
    endcase
    // A stale rvalid landing with the redirect is consumed now, so DROP is
    // only needed while a granted request is still unanswered.
    if (redirect) begin
      if (w_gnt || (((r_state == S_WAIT) || (r_state == S_DROP)) && !imem_rvalid))
        w_nxt = S_DROP;
      else
        w_nxt = w_mis ? S_ERR : S_REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_REQ;
      r_pc             <= RESET_PC;
      r_req_pc         <= '0;
      r_buf_valid      <= 1'b0;
      r_buf_instr      <= NOP;
      r_buf_pc         <= '0;
      r_if_id_valid    <= 1'b0;
      r_if_id_instr    <= NOP;
      r_if_id_pc       <= '0;
      r_if_id_misalign <= 1'b0;
      r_mis_pend       <= 1'b0;
      r_mis_tgt        <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_gnt) r_req_pc <= r_pc;
      if (redirect) begin
        r_pc             <= w_tgt;
        r_buf_valid      <= 1'b0;
        r_if_id_valid    <= 1'b0;
        r_if_id_misalign <= 1'b0;
        r_mis_pend       <= w_mis;
        r_mis_tgt        <= w_mis;
      end else begin
        if (w_gnt) r_pc <= r_pc + ADDR_WIDTH'(4);
        if (w_rsp && stall) begin
          r_buf_valid <= 1'b1;
          r_buf_instr <= imem_rdata;
          r_buf_pc    <= r_req_pc;
        end
        if (!stall) begin
          if (r_mis_pend) begin
            // pc is frozen on the misaligned target: no grants since the redirect
            r_if_id_valid    <= 1'b1;
            r_if_id_instr    <= NOP;
            r_if_id_pc       <= r_pc;
            r_if_id_misalign <= 1'b1;
            r_mis_pend       <= 1'b0;
          end else if (r_buf_valid) begin
            r_if_id_valid    <= 1'b1;
            r_if_id_instr    <= r_buf_instr;
            r_if_id_pc       <= r_buf_pc;
            r_if_id_misalign <= 1'b0;
            r_buf_valid      <= 1'b0;
          end else if (w_rsp) begin
            r_if_id_valid    <= 1'b1;
            r_if_id_instr    <= imem_rdata;
            r_if_id_pc       <= r_req_pc;
            r_if_id_misalign <= 1'b0;
          end else begin
            r_if_id_valid    <= 1'b0;
            r_if_id_instr    <= NOP;
            r_if_id_misalign <= 1'b0;
          end
        end
      end
    end
  end

endmodule
